nibble_serial_adder: RTL and testbench
======================================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, the upstream operand-valid signal.
REQ-005 The block SHALL have port in_ready, output, 1, the operand-accept signal.
REQ-006 The block SHALL have ports a and b, input, W each, the addends.
REQ-007 The block SHALL have port cin, input, 1, the carry into nibble 0.
REQ-008 The block SHALL have port out_valid, output, 1, the result-valid signal.
REQ-009 The block SHALL have port out_ready, input, 1, the downstream accept signal.
REQ-010 The block SHALL have port sum, output, W, the registered result.
REQ-011 The block SHALL have port cout, output, 1, the registered carry out of the top nibble.
REQ-012 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, in_valid=1 SHALL latch a, b and cin, clear the slice index to 0 and move to RUN; in_valid=0 SHALL keep the block in IDLE.
REQ-016 Each RUN cycle SHALL add slice idx of a and b plus the carry register through a 4-bit carry-select slice (both carry hypotheses computed, selected by the carry register), write the 4-bit result into sum[4*idx+3:4*idx], update the carry register and increment idx.
REQ-017 After slice NIBBLES-1 the FSM SHALL load cout from the final carry and move to DONE.
REQ-018 out_valid SHALL rise exactly NIBBLES cycles after the accepting edge.
REQ-019 out_valid SHALL be 1 only in DONE.
REQ-020 sum and cout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 In DONE, out_ready=1 SHALL return the FSM to IDLE on that edge; the next operand SHALL be accepted no earlier than the following edge.
REQ-022 sum SHALL equal (a + b + cin) mod 2^W and cout SHALL equal bit W of a + b + cin.
REQ-023 Input changes after the accepting edge SHALL have no effect on the result.
REQ-024 sum bits not yet written in RUN SHALL hold 0.
REQ-025 idx SHALL never wrap during RUN.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set sum=0, cout=0, out_valid=0, busy=0, the carry register=0 and idx=0, in any state, including mid-RUN and in DONE while stalled.
REQ-027 in_ready SHALL be 1 in the cycle after reset release.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge.
REQ-029 An operation interrupted by reset SHALL produce no out_valid pulse.

Configuration
REQ-030 With macro NIBBLE_SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf, 1 bit, registered with cout and cleared by reset, equal to the carry into the MSB XOR the carry out of the MSB (two's-complement overflow).
REQ-031 Without NIBBLE_SERIAL_ADDER_OVF_EN defined, ovf SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 a=16'h0001, b=16'hFFFF, cin=0, out_ready=1 -> out_valid rises 4 cycles after accept with sum=16'h0000, cout=1.
REQ-033 a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; busy=1 and in_ready=0 from accept until the return to IDLE.
REQ-034 out_ready held 0 for 3 cycles after out_valid rises -> sum and cout unchanged and in_ready=0 throughout; out_ready=1 -> IDLE next edge and in_ready=1.
REQ-035 rst asserted for one edge in the 2nd RUN cycle -> next cycle sum=0, cout=0, busy=0, in_ready=1, and no out_valid for that operand.
REQ-036 Two operations back-to-back, 16'hFFFF+16'hFFFF cin=1 then 16'h8000+16'h8000 cin=0 -> results 16'hFFFF/cout=1, then 16'h0000/cout=1.
REQ-037 With NIBBLE_SERIAL_ADDER_OVF_EN defined: 16'h7FFF+16'h0001 -> ovf=1; 16'hFFFF+16'h0001 -> ovf=0 and cout=1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder: one 4-bit carry-select slice per cycle, valid/ready on both sides.
// Optional two's-complement overflow output enabled by defining NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic              carry_q;
    logic [IDX_W-1:0]  idx_q;
    logic [W-1:0]      sum_q;
    logic              cout_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic              ovf_q;
`endif

    logic [3:0]        a_nib;
    logic [3:0]        b_nib;
    logic [4:0]        sum_c0;
    logic [4:0]        sum_c1;
    logic [4:0]        slice_d;

    // Carry-select slice: both carry hypotheses computed, carry register picks one.
    always_comb begin
        a_nib   = a_q[{idx_q, 2'b00} +: 4];
        b_nib   = b_q[{idx_q, 2'b00} +: 4];
        sum_c0  = {1'b0, a_nib} + {1'b0, b_nib};
        sum_c1  = {1'b0, a_nib} + {1'b0, b_nib} + 5'd1;
        slice_d = carry_q ? sum_c1 : sum_c0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= slice_d[3:0];
                    carry_q                    <= slice_d[4];
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_d[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        // Carry into the MSB recovered from the MSB operand bits and result bit.
                        ovf_q       <= (a_nib[3] ^ b_nib[3] ^ slice_d[3]) ^ slice_d[4];
`endif
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4, 16-bit operands).
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic        ovf;
`endif

    int tests;
    int fails;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, presents one operand for the accepting edge, then scrambles inputs.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL start_op_ready: in_ready=%b required 1 within 20 cycles", in_ready);
        end
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        tick();
        in_valid = 1'b0;
        a = ~av ^ 16'h5A5A;
        b = bv + 16'h1357;
        cin = ~cv;
    endtask

    // Counts cycles after the accepting edge until out_valid, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if ({in_ready, busy, out_valid, cout} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags: in_ready/busy/out_valid/cout=%b required 1000",
                     {in_ready, busy, out_valid, cout});
        end
        tests++;
        if (sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_sum: sum=%h required 0000", sum);
        end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        start_op(16'h0001, 16'hFFFF, 1'b0);
        wait_done(cyc);
        tests++;
        if (cyc !== 4) begin
            fails++;
            $display("FAIL basic_latency: cycles=%0d required 4", cyc);
        end
        tests++;
        if ({cout, sum} !== 17'h1_0000) begin
            fails++;
            $display("FAIL basic_result: cout=%b sum=%h required cout=1 sum=0000", cout, sum);
        end
        tick();
        tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL basic_return_idle: out_valid/in_ready/busy=%b required 010",
                     {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_busy();
        int bad;
        out_ready = 1'b0;
        start_op(16'h1234, 16'h4321, 1'b1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            tick();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL busy_during_run: bad cycles=%0d required 0", bad);
        end
        tests++;
        if ({out_valid, busy, in_ready} !== 3'b110) begin
            fails++;
            $display("FAIL busy_done_flags: out_valid/busy/in_ready=%b required 110",
                     {out_valid, busy, in_ready});
        end
        tests++;
        if ({cout, sum} !== 17'h0_5556) begin
            fails++;
            $display("FAIL busy_result: cout=%b sum=%h required cout=0 sum=5556", cout, sum);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({busy, in_ready, out_valid} !== 3'b010) begin
            fails++;
            $display("FAIL busy_release: busy/in_ready/out_valid=%b required 010",
                     {busy, in_ready, out_valid});
        end
    endtask

    task automatic test_stall();
        int cyc;
        int bad;
        out_ready = 1'b0;
        start_op(16'h9ABC, 16'h8765, 1'b0);
        wait_done(cyc);
        tests++;
        if (cyc !== 4 || {cout, sum} !== 17'h1_2221) begin
            fails++;
            $display("FAIL stall_result: cycles=%0d cout=%b sum=%h required 4 1 2221", cyc, cout, sum);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({cout, sum} !== 17'h1_2221 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stall_hold: bad cycles=%0d required 0", bad);
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL stall_release: in_ready/out_valid=%b required 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        out_ready = 1'b1;
        start_op(16'h1111, 16'h2222, 1'b0);
        tick();
        tests++;
        if (sum !== 16'h0003) begin
            fails++;
            $display("FAIL partial_sum: sum=%h required 0003", sum);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({sum, cout, busy, in_ready, out_valid} !== {16'h0000, 4'b0010}) begin
            fails++;
            $display("FAIL midrun_reset: sum=%h cout=%b busy=%b in_ready=%b out_valid=%b required 0000 0 0 1 0",
                     sum, cout, busy, in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midrun_no_valid: out_valid cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        out_ready = 1'b1;
        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(cyc);
        tests++;
        if (cyc !== 4 || {cout, sum} !== 17'h1_FFFF) begin
            fails++;
            $display("FAIL b2b_first: cycles=%0d cout=%b sum=%h required 4 1 ffff", cyc, cout, sum);
        end
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_accept_in_done: in_ready=%b required 0", in_ready);
        end
        start_op(16'h8000, 16'h8000, 1'b0);
        wait_done(cyc);
        tests++;
        if (cyc !== 4 || {cout, sum} !== 17'h1_0000) begin
            fails++;
            $display("FAIL b2b_second: cycles=%0d cout=%b sum=%h required 4 1 0000", cyc, cout, sum);
        end
        tick();
    endtask

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int cyc;
        out_ready = 1'b1;
        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done(cyc);
        tests++;
        if ({ovf, cout, sum} !== 18'b10_1000_0000_0000_0000) begin
            fails++;
            $display("FAIL ovf_pos: ovf=%b cout=%b sum=%h required 1 0 8000", ovf, cout, sum);
        end
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc);
        tests++;
        if ({ovf, cout, sum} !== 18'b01_0000_0000_0000_0000) begin
            fails++;
            $display("FAIL ovf_wrap: ovf=%b cout=%b sum=%h required 0 1 0000", ovf, cout, sum);
        end
        tick();
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_busy();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
